// File: rtl/gb_timer_pkg.sv
// Shared constants for the Game Boy timer/divider: register selects, TAC
// clock-select encodings, reload FSM states and the interrupt bit position.
`timescale 1ns/1ps
package gb_timer_pkg;

    localparam logic [3:0] TIMER_SEL_DIV  = 4'h4;
    localparam logic [3:0] TIMER_SEL_TIMA = 4'h5;
    localparam logic [3:0] TIMER_SEL_TMA  = 4'h6;
    localparam logic [3:0] TIMER_SEL_TAC  = 4'h7;

    localparam logic [1:0] TAC_CLK_4096   = 2'b00;
    localparam logic [1:0] TAC_CLK_262144 = 2'b01;
    localparam logic [1:0] TAC_CLK_65536  = 2'b10;
    localparam logic [1:0] TAC_CLK_16384  = 2'b11;

    localparam int TAC_ENABLE_BIT = 2;
    localparam int TIMER_INT_BIT  = 2;

    typedef enum logic [1:0] {
        TIMER_IDLE   = 2'd0,
        TIMER_DELAY  = 2'd1,
        TIMER_RELOAD = 2'd2
    } timer_state_t;

    // Counter bit watched for each TAC clock select: {9, 3, 5, 7}.
    function automatic int tac_bit_index(input logic [1:0] clk_sel);
        case (clk_sel)
            TAC_CLK_4096:   return 9;
            TAC_CLK_262144: return 3;
            TAC_CLK_65536:  return 5;
            default:        return 7;
        endcase
    endfunction

endpackage

// File: rtl/gb_timer_tick_gen.sv
// TIMA tick source: picks the TAC-selected counter bit, gates it with the
// enable and emits a one-cycle pulse on its falling edge.
`timescale 1ns/1ps
module gb_timer_tick_gen
    import gb_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic [COUNTER_WIDTH-1:0] iCounter,
    input  logic [2:0]               iTac,
    output logic                     oTick
);

    localparam int IDX_W = $clog2(COUNTER_WIDTH);

    logic [IDX_W-1:0] sel_idx;
    logic             tick_in;
    logic             tick_in_p1;

    assign sel_idx = IDX_W'(tac_bit_index(iTac[1:0]));
    assign tick_in = iTac[TAC_ENABLE_BIT] & iCounter[sel_idx];

    // Stage p1: previous tick_in; disabling TAC or clearing DIV while the
    // selected bit is high also reads as a falling edge, as on real hardware.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            tick_in_p1 <= 1'b0;
        else
            tick_in_p1 <= tick_in;
    end

    assign oTick = tick_in_p1 & ~tick_in;

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer with the delayed TMA reload after TIMA
// overflow and a registered one-cycle timer interrupt request.
`timescale 1ns/1ps
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int RELOAD_DELAY  = 4
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iMcuWe,
    input  logic [3:0] iMcuRegSelect,
    input  logic [7:0] iMcuWriteData,
    output logic [7:0] oDiv,
    output logic [7:0] oTima,
    output logic [7:0] oTma,
    output logic [7:0] oTac,
    output logic       oTimerInterrupt
);

    localparam logic [3:0] DELAY_INIT = 4'(RELOAD_DELAY - 1);

    logic [COUNTER_WIDTH-1:0] counter;
    logic [7:0]               tima;
    logic [7:0]               tma;
    logic [2:0]               tac;
    logic [3:0]               delay_cnt;
    logic                     irq;
    timer_state_t             state, state_nxt;

    logic tick;
    logic div_we, tima_we, tma_we, tac_we;
    logic tima_load, tima_inc, overflow, reload_go, tma_follow;

    assign div_we  = iMcuWe && (iMcuRegSelect == TIMER_SEL_DIV);
    assign tima_we = iMcuWe && (iMcuRegSelect == TIMER_SEL_TIMA);
    assign tma_we  = iMcuWe && (iMcuRegSelect == TIMER_SEL_TMA);
    assign tac_we  = iMcuWe && (iMcuRegSelect == TIMER_SEL_TAC);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            counter <= '0;
        else if (div_we)
            counter <= '0;
        else
            counter <= counter + 1'b1;
    end

    gb_timer_tick_gen #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_tick_gen (
        .iClock  (iClock),
        .iReset  (iReset),
        .iCounter(counter),
        .iTac    (tac),
        .oTick   (tick)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            state <= TIMER_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TIMER_IDLE:   if (overflow) state_nxt = TIMER_DELAY;
            TIMER_DELAY:  if (tima_we) state_nxt = TIMER_IDLE;
                          else if (delay_cnt == 4'd0) state_nxt = TIMER_RELOAD;
            TIMER_RELOAD: state_nxt = TIMER_IDLE;
            default:      state_nxt = TIMER_IDLE;
        endcase
    end

    // In the reload cycle TIMA already shows TMA: CPU TIMA writes are dropped
    // and TMA writes pass straight through to TIMA.
    always_comb begin
        tima_load  = tima_we && (state != TIMER_RELOAD);
        tima_inc   = tick && (state == TIMER_IDLE) && !tima_we;
        overflow   = tima_inc && (tima == 8'hFF);
        reload_go  = (state == TIMER_DELAY) && (delay_cnt == 4'd0) && !tima_we;
        tma_follow = (state == TIMER_RELOAD) && tma_we;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            delay_cnt <= 4'd0;
            irq       <= 1'b0;
        end else begin
            if (tima_load)
                tima <= iMcuWriteData;
            else if (reload_go)
                tima <= tma_we ? iMcuWriteData : tma;
            else if (tma_follow)
                tima <= iMcuWriteData;
            else if (tima_inc)
                tima <= tima + 8'd1;

            if (tma_we)
                tma <= iMcuWriteData;
            if (tac_we)
                tac <= iMcuWriteData[2:0];

            if (overflow)
                delay_cnt <= DELAY_INIT;
            else if ((state == TIMER_DELAY) && (delay_cnt != 4'd0))
                delay_cnt <= delay_cnt - 4'd1;

            irq <= reload_go;
        end
    end

    assign oDiv            = counter[COUNTER_WIDTH-1 -: 8];
    assign oTima           = tima;
    assign oTma            = tma;
    assign oTac            = {5'b11111, tac};
    assign oTimerInterrupt = irq;

endmodule
